// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Brief    : Shared fetch FSM encoding, NOP word and RV32I opcode[6:2] values.
// Revision : 1.0
// ============================================================================
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  // opcode[6:2] values shared with decode and immediate extension
  localparam logic [4:0] c_OPC_LOAD     = 5'b00000;
  localparam logic [4:0] c_OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] c_OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] c_OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] c_OPC_STORE    = 5'b01000;
  localparam logic [4:0] c_OPC_OP       = 5'b01100;
  localparam logic [4:0] c_OPC_LUI      = 5'b01101;
  localparam logic [4:0] c_OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] c_OPC_JALR     = 5'b11001;
  localparam logic [4:0] c_OPC_JAL      = 5'b11011;
  localparam logic [4:0] c_OPC_SYSTEM   = 5'b11100;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Brief    : One-entry fetch output register; load has priority over clear.
// Revision : 1.0
// ============================================================================
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_fault,
  input  logic        i_clear,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_fault
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= c_NOP;
      r_pc    <= 32'h0;
      r_fault <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_fault <= i_fault;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_fault = r_fault;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : RV32I fetch stage: PC, single-outstanding imem request, redirect
//            kill. Define IF_MISALIGN_CHECK_EN to trap misaligned redirects.
// Revision : 1.0
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_kill;

  logic         w_misalign;
  logic [31:0]  w_redir_pc;
  logic         w_req_fire;
  logic         w_capture;
  logic         w_stale;
  logic         w_load;
  logic         w_clear;
  logic         w_buf_valid;

`ifdef IF_MISALIGN_CHECK_EN
  assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc = redirect_pc;
`else
  assign w_misalign = 1'b0;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign imem_req_valid = (r_state == ST_REQ) && !redirect_valid && !rst;
  assign imem_addr      = r_pc;
  assign inst_valid     = w_buf_valid && !redirect_valid;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_capture  = !redirect_valid && (r_state == ST_WAIT) && imem_rsp_valid && !r_kill;
  // A request is still owed a response after this cycle; it must be drained.
  assign w_stale    = ((r_state == ST_WAIT) || r_kill) && !imem_rsp_valid;
  assign w_load     = w_capture || w_misalign;
  assign w_clear    = (r_state == ST_HOLD) && (redirect_valid || inst_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= ST_REQ;
      r_kill  <= 1'b0;
    end else if (redirect_valid) begin
      r_pc   <= w_redir_pc;
      r_kill <= w_stale;
      if (w_misalign)
        r_state <= ST_HOLD;
      else if (w_stale)
        r_state <= ST_WAIT;
      else
        r_state <= ST_REQ;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_req_fire)
            r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_kill <= 1'b0;
            if (r_kill) begin
              r_state <= ST_REQ;
            end else begin
              r_pc    <= r_pc + 32'd4;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (imem_rsp_valid)
            r_kill <= 1'b0;
          if (inst_ready)
            r_state <= w_stale ? ST_WAIT : ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_inst  (w_misalign ? c_NOP : imem_rsp_data),
    .i_pc    (w_misalign ? redirect_pc : r_pc),
    .i_fault (w_misalign),
    .i_clear (w_clear),
    .o_valid (w_buf_valid),
    .o_inst  (inst),
    .o_pc    (inst_pc),
    .o_fault (inst_fault)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Self-checking bench for inst_fetch with a latency-programmable
//            instruction memory and an expected-PC stream model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int lat;

  bit          pend_v;
  int          pend_due;
  logic [31:0] pend_addr;

  logic [31:0] m_pc;
  bit          prev_hold;
  logic [31:0] prev_inst, prev_pc;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h0050_0093 + {a[23:0], 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // which: 0 = inst_valid, 1 = imem_req_valid, 2 = transfer, 3 = request at addr tgt
  task automatic wait_for(input int which, input logic [31:0] tgt, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = inst_valid;
        1: hit = imem_req_valid;
        2: hit = inst_valid && inst_ready;
        default: hit = imem_req_valid && (imem_addr == tgt);
      endcase
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout waiting for event %0d (cycle %0d)", which, cyc);
    end
  endtask

  // Memory: response k=lat cycles after the accepting cycle
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_v && pend_due == cyc && !rst) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memw(pend_addr);
        pend_v = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    pend_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_v = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        check("one_outstanding", {31'd0, pend_v}, 32'd0);
        pend_v    = 1'b1;
        pend_due  = cyc + lat;
        pend_addr = imem_addr;
      end
    end
  end

  // Stream model: next delivered instruction must carry the expected PC
  initial begin
    m_pc = 32'h0;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pc = 32'h0;
        prev_hold = 1'b0;
      end else begin
        if (redirect_valid) begin
          check("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
          check("redir_no_valid", {31'd0, inst_valid}, 32'd0);
        end
        if (imem_req_valid) begin
          check("req_excl_valid", {31'd0, inst_valid}, 32'd0);
          check("req_addr", imem_addr, m_pc);
        end
        if (inst_valid) begin
          check("inst_pc", inst_pc, m_pc);
          if (inst_fault)
            check("fault_nop", inst, c_NOP);
          else
            check("inst_word", inst, memw(inst_pc));
`ifndef IF_MISALIGN_CHECK_EN
          check("fault_tied0", {31'd0, inst_fault}, 32'd0);
`endif
          if (prev_hold) begin
            check("stable_inst", inst, prev_inst);
            check("stable_pc", inst_pc, prev_pc);
          end
        end
        prev_hold = inst_valid && !inst_ready;
        prev_inst = inst;
        prev_pc   = inst_pc;
        if (redirect_valid) begin
`ifdef IF_MISALIGN_CHECK_EN
          m_pc = redirect_pc;
`else
          m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else if (inst_valid && inst_ready && !inst_fault) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst", inst, c_NOP);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fault", {31'd0, inst_fault}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // first fetch, zero-wait memory
    @(negedge clk);
    check("first_req", {31'd0, imem_req_valid}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    t0 = cyc;
    wait_for(0, 32'h0, 10);
    check("first_latency", 32'(cyc - t0), 32'd2);
    check("first_inst", inst, 32'h0050_0093);
    check("first_pc", inst_pc, 32'h0);

    // decode stall
    repeat (5) begin
      @(negedge clk);
      check("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
    end
    check("stall_inst", inst, 32'h0050_0093);

    // redirect while the fetch of 0x8 is in flight
    @(posedge clk); #1 inst_ready = 1'b1; lat = 3;
    wait_for(3, 32'h8, 40);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b0;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_for(1, 32'h0, 20);
    check("kill_next_addr", imem_addr, 32'h100);
    wait_for(0, 32'h0, 20);
    check("kill_inst_pc", inst_pc, 32'h100);
    check("kill_inst", inst, 32'h0051_0093);

    // redirect in HOLD coincident with inst_ready
    @(posedge clk); #1 inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; lat = 1;
    @(negedge clk);
    check("hold_redir_noxfer", {31'd0, inst_valid}, 32'd0);
    @(posedge clk); #1 redirect_valid = 1'b0; inst_ready = 1'b0;
    wait_for(0, 32'h0, 20);
    check("hold_redir_pc", inst_pc, 32'h200);

    // PC wrap
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_for(0, 32'h0, 20);
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1 inst_ready = 1'b1;
    wait_for(1, 32'h0, 20);
    check("wrap_addr", imem_addr, 32'h0);

    // throughput with k=1 and decode always ready
    wait_for(2, 32'h0, 20);
    t1 = cyc;
    wait_for(2, 32'h0, 20);
    check("throughput", 32'(cyc - t1), 32'd3);

    // misaligned redirect
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1 redirect_valid = 1'b0; inst_ready = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    @(negedge clk);
    check("mis_valid", {31'd0, inst_valid}, 32'd1);
    check("mis_fault", {31'd0, inst_fault}, 32'd1);
    check("mis_inst", inst, c_NOP);
    check("mis_pc", inst_pc, 32'h102);
    check("mis_noreq", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_for(0, 32'h0, 20);
    check("mis_recover_pc", inst_pc, 32'h300);
    check("mis_recover_fault", {31'd0, inst_fault}, 32'd0);
`else
    wait_for(1, 32'h0, 20);
    check("mis_addr", imem_addr, 32'h100);
    wait_for(0, 32'h0, 20);
    check("mis_pc", inst_pc, 32'h100);
    check("mis_fault", {31'd0, inst_fault}, 32'd0);
`endif

    // reset while a request is outstanding
    @(posedge clk); #1 inst_ready = 1'b1; lat = 5;
    wait_for(1, 32'h0, 20);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst2_inst", inst, c_NOP);
    check("rst2_inst_pc", inst_pc, 32'h0);
    check("rst2_addr", imem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0; lat = 1; inst_ready = 1'b0;
    wait_for(0, 32'h0, 20);
    check("rst2_first_pc", inst_pc, 32'h0);
    check("rst2_first_inst", inst, 32'h0050_0093);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
